matmul_seq: RTL and testbench

MATMUL_SEQ -- requirements
Module: matmul_seq

---
 rtl/matmul_seq.sv | 130 +++++++++++++
 tb/tb_matmul_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_seq.sv
// Sequential matrix multiplier C = A*B over a single shared, arbitrated word memory.
// Optional busy-cycle counter on clock_count when MATMUL_SEQ_PERF_CNT_EN is defined.
module matmul_seq #(
   parameter int M  = 100,
   parameter int N  = 50,
   parameter int N2 = 2,
   parameter int DW = 32,
   parameter int AW = 16
) (
   input  logic          CLOCK_50,
   input  logic          rst_n,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          mem_req,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_gnt,
   input  logic [DW-1:0] mem_rdata,
   output logic [31:0]   clock_count
);

   localparam int IW = (M  > 1) ? $clog2(M)  : 1;
   localparam int JW = (N2 > 1) ? $clog2(N2) : 1;
   localparam int KW = (N  > 1) ? $clog2(N)  : 1;
   localparam logic [AW-1:0] B_BASE = AW'(M*N);
   localparam logic [AW-1:0] C_BASE = AW'(M*N + N*N2);

   typedef enum logic [2:0] {IDLE, RD_A, WAIT_A, RD_B, WAIT_B, WR, DONE} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] i;
   logic [JW-1:0] j;
   logic [KW-1:0] k;
   logic [DW-1:0] acc, a_reg;
   logic          last_i, last_j, last_k, accept;

   assign last_i = (i == IW'(M-1));
   assign last_j = (j == JW'(N2-1));
   assign last_k = (k == KW'(N-1));
   assign accept = start && (state == IDLE || state == DONE);

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Request outputs decode straight from state and counters, so they stay
   // frozen while a grant is withheld and drop to zero the instant reset hits.
   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         IDLE, DONE: if (start) state_nxt = RD_A;
         RD_A: begin
            mem_req  = 1'b1;
            mem_addr = AW'(i) * AW'(N) + AW'(k);
            if (mem_gnt) state_nxt = WAIT_A;
         end
         WAIT_A: state_nxt = RD_B;
         RD_B: begin
            mem_req  = 1'b1;
            mem_addr = B_BASE + AW'(k) * AW'(N2) + AW'(j);
            if (mem_gnt) state_nxt = WAIT_B;
         end
         WAIT_B: state_nxt = last_k ? WR : RD_A;
         WR: begin
            mem_req   = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = C_BASE + AW'(i) * AW'(N2) + AW'(j);
            mem_wdata = acc;
            if (mem_gnt) state_nxt = (last_i && last_j) ? DONE : RD_A;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE) && (state != DONE);
   assign done = (state == DONE);

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         i     <= '0;
         j     <= '0;
         k     <= '0;
         acc   <= '0;
         a_reg <= '0;
      end else if (accept) begin
         i   <= '0;
         j   <= '0;
         k   <= '0;
         acc <= '0;
      end else begin
         case (state)
            WAIT_A: a_reg <= mem_rdata;
            WAIT_B: begin
               // low DW bits of the product are the same signed or unsigned
               acc <= acc + a_reg * mem_rdata;
               if (!last_k) k <= k + 1'b1;
            end
            WR: if (mem_gnt) begin
               acc <= '0;
               k   <= '0;
               if (!last_j) begin
                  j <= j + 1'b1;
               end else begin
                  j <= '0;
                  i <= i + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MATMUL_SEQ_PERF_CNT_EN
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n)                                clock_count <= '0;
      else if (accept)                           clock_count <= '0;
      else if (busy && clock_count != '1)        clock_count <= clock_count + 32'd1;
   end
`else
   assign clock_count = '0;
`endif

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq: three instances (2x2x1, 1x1x1, default size)
// each backed by a behavioural word memory with programmable grant stalls.
module tb_matmul_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef MATMUL_SEQ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // ---------------- instance A: M=2, N=2, N2=1 ----------------
   logic        rst_n_a, start_a, busy_a, done_a, req_a, wr_a, gnt_a;
   logic [15:0] addr_a;
   logic [31:0] wdata_a, rdata_a, cc_a;
   logic [31:0] mem_a [0:7];
   logic [15:0] log_a [$];
   logic        stall_en;
   int          stall_cnt;

   matmul_seq #(.M(2), .N(2), .N2(1)) dut_a (
      .CLOCK_50(clk), .rst_n(rst_n_a), .start(start_a), .busy(busy_a), .done(done_a),
      .mem_req(req_a), .mem_wr(wr_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
      .mem_gnt(gnt_a), .mem_rdata(rdata_a), .clock_count(cc_a));

   // withhold the grant for 3 cycles on every read of B[0][0] (address 4)
   assign gnt_a = !(stall_en && req_a && !wr_a && addr_a == 16'd4 && stall_cnt < 3);

   always @(posedge clk) begin
      if (req_a && gnt_a) begin
         stall_cnt <= 0;
         log_a.push_back(addr_a);
         if (wr_a) mem_a[addr_a[2:0]] <= wdata_a;
         else      rdata_a <= mem_a[addr_a[2:0]];
      end else if (!gnt_a) begin
         stall_cnt <= stall_cnt + 1;
      end
   end

   // ---------------- instance B: M=N=N2=1 ----------------
   logic        rst_n, start_b, busy_b, done_b, req_b, wr_b;
   logic        gnt_b = 1'b1;
   logic [15:0] addr_b;
   logic [31:0] wdata_b, rdata_b, cc_b;
   logic [31:0] mem_b [0:3];

   matmul_seq #(.M(1), .N(1), .N2(1)) dut_b (
      .CLOCK_50(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
      .mem_req(req_b), .mem_wr(wr_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
      .mem_gnt(gnt_b), .mem_rdata(rdata_b), .clock_count(cc_b));

   always @(posedge clk)
      if (req_b && gnt_b) begin
         if (wr_b) mem_b[addr_b[1:0]] <= wdata_b;
         else      rdata_b <= mem_b[addr_b[1:0]];
      end

   // ---------------- instance C: default 100x50x2 ----------------
   logic        start_c, busy_c, done_c, req_c, wr_c;
   logic        gnt_c = 1'b1;
   logic [15:0] addr_c;
   logic [31:0] wdata_c, rdata_c, cc_c;
   logic [31:0] mem_c [0:8191];
   logic [31:0] ref_c [0:199];

   matmul_seq dut_c (
      .CLOCK_50(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
      .mem_req(req_c), .mem_wr(wr_c), .mem_addr(addr_c), .mem_wdata(wdata_c),
      .mem_gnt(gnt_c), .mem_rdata(rdata_c), .clock_count(cc_c));

   always @(posedge clk)
      if (req_c && gnt_c) begin
         if (wr_c) mem_c[addr_c[12:0]] <= wdata_c;
         else      rdata_c <= mem_c[addr_c[12:0]];
      end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic set_start(input int sel, input logic v);
      case (sel)
         0: start_a = v;
         1: start_b = v;
         default: start_c = v;
      endcase
   endtask

   function automatic logic get_done(input int sel);
      case (sel)
         0: return done_a;
         1: return done_b;
         default: return done_c;
      endcase
   endfunction

   // returns the number of edges from the start-sampling edge to done high
   task automatic run(input int sel, input int pulse_at, input int budget, output int cyc);
      @(negedge clk);
      set_start(sel, 1'b1);
      @(posedge clk);
      #1 set_start(sel, 1'b0);
      cyc = 0;
      while (cyc < budget) begin
         @(posedge clk);
         #1 cyc++;
         set_start(sel, cyc == pulse_at);
         if (get_done(sel)) break;
      end
      set_start(sel, 1'b0);
   endtask

   task automatic chk_log(input string nm);
      logic [15:0] exp_seq [0:9];
      exp_seq = '{16'd0, 16'd4, 16'd1, 16'd5, 16'd6, 16'd2, 16'd4, 16'd3, 16'd5, 16'd7};
      chk({nm, "_len"}, 32'(log_a.size()), 32'd10);
      for (int n = 0; n < 10 && n < log_a.size(); n++)
         chk($sformatf("%s_addr%0d", nm, n), 32'(log_a[n]), 32'(exp_seq[n]));
   endtask

   task automatic load_a(input logic [31:0] c7);
      mem_a = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd0, c7};
      log_a.delete();
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
   } vec_t;

   initial begin
      vec_t vecs [6];
      int   cyc;
      logic [31:0] acc;

      vecs[0] = '{32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB};  // -3*7
      vecs[1] = '{32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFE};
      vecs[2] = '{32'd5,         32'd6,         32'd30};
      vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
      vecs[5] = '{32'h0001_0000, 32'h0001_0000, 32'd0};

      rst_n_a = 1'b0; rst_n = 1'b0;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      stall_en = 1'b0; stall_cnt = 0;
      #23;
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_req",  32'(req_a),  32'd0);
      chk("rst_addr", 32'(addr_a), 32'd0);
      chk("rst_wdata", wdata_a,    32'd0);
      chk("rst_cc",   cc_a,        32'd0);
      @(negedge clk);
      rst_n_a = 1'b1; rst_n = 1'b1;

      // basic 2x2x1, grant always high
      load_a(32'd0);
      run(0, -1, 100, cyc);
      chk("a_latency", 32'(cyc), 32'd18);
      chk("a_c0", mem_a[6], 32'd17);
      chk("a_c1", mem_a[7], 32'd39);
      chk("a_cc", cc_a, PERF ? 32'd18 : 32'd0);
      chk_log("a_seq");
      repeat (3) @(posedge clk);
      #1 chk("a_done_held", 32'(done_a), 32'd1);
      chk("a_busy_idle", 32'(busy_a), 32'd0);

      // start pulsed mid-run must be ignored
      load_a(32'd0);
      run(0, 5, 100, cyc);
      chk("ign_latency", 32'(cyc), 32'd18);
      chk("ign_c0", mem_a[6], 32'd17);
      chk("ign_c1", mem_a[7], 32'd39);
      chk_log("ign_seq");

      // 3-cycle grant stall on each B[0][0] read: two reads, +6 cycles
      load_a(32'd0);
      stall_en = 1'b1;
      run(0, -1, 100, cyc);
      stall_en = 1'b0;
      chk("stall_latency", 32'(cyc), 32'd24);
      chk("stall_c0", mem_a[6], 32'd17);
      chk("stall_c1", mem_a[7], 32'd39);
      chk("stall_cc", cc_a, PERF ? 32'd24 : 32'd0);
      chk_log("stall_seq");

      // reset during the second write
      load_a(32'hDEAD_BEEF);
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      cyc = 0;
      while (cyc < 100 && !(req_a && wr_a && addr_a == 16'd7)) begin
         @(posedge clk);
         #1 cyc++;
      end
      chk("rstmid_found", 32'(cyc < 100), 32'd1);
      rst_n_a = 1'b0;
      #1;
      chk("rstmid_busy", 32'(busy_a), 32'd0);
      chk("rstmid_done", 32'(done_a), 32'd0);
      chk("rstmid_req",  32'(req_a),  32'd0);
      @(negedge clk);
      rst_n_a = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("rstmid_no_restart", 32'(busy_a), 32'd0);
      chk("rstmid_c0", mem_a[6], 32'd17);
      chk("rstmid_c1", mem_a[7], 32'hDEAD_BEEF);
      log_a.delete();
      run(0, -1, 100, cyc);
      chk("restart_latency", 32'(cyc), 32'd18);
      chk("restart_c1", mem_a[7], 32'd39);

      // 1x1x1 signed / wrap vectors
      foreach (vecs[n]) begin
         mem_b[0] = vecs[n].a;
         mem_b[1] = vecs[n].b;
         mem_b[2] = 32'd0;
         run(1, -1, 50, cyc);
         chk($sformatf("v%0d_c", n), mem_b[2], vecs[n].c);
         chk($sformatf("v%0d_latency", n), 32'(cyc), 32'd5);
         chk($sformatf("v%0d_cc", n), cc_b, PERF ? 32'd5 : 32'd0);
      end

      // default size with random data against a reference model
      for (int n = 0; n < 5100; n++) mem_c[n] = $urandom;
      for (int n = 5100; n < 5300; n++) mem_c[n] = 32'd0;
      for (int r = 0; r < 100; r++)
         for (int c = 0; c < 2; c++) begin
            acc = 32'd0;
            for (int q = 0; q < 50; q++)
               acc = acc + mem_c[r*50 + q] * mem_c[5000 + q*2 + c];
            ref_c[r*2 + c] = acc;
         end
      run(2, -1, 45000, cyc);
      chk("big_latency", 32'(cyc), 32'd40200);
      chk("big_cc", cc_c, PERF ? 32'd40200 : 32'd0);
      for (int n = 0; n < 200; n++)
         chk($sformatf("big_c%0d", n), mem_c[5100 + n], ref_c[n]);
      chk("big_busy", 32'(busy_c), 32'd0);
      chk("b_busy", 32'(busy_b), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
